// File: rtl/br_predictor_if.sv
// Fetch/execute-side bundle for the branch predictor: lookup, resolve update,
// flush and statistics. The predictor attaches through the slave modport.
interface br_predictor_if;
  logic [31:0] lk_pc;
  logic        pred_hit;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic        upd_taken;
  logic [31:0] upd_target;
  logic        upd_mispredict;
  logic        flush;
  logic [31:0] stat_branches;
  logic [31:0] stat_mispredicts;

  modport master (
    output lk_pc, upd_valid, upd_pc, upd_taken, upd_target, upd_mispredict, flush,
    input  pred_hit, pred_taken, pred_target, stat_branches, stat_mispredicts
  );

  modport slave (
    input  lk_pc, upd_valid, upd_pc, upd_taken, upd_target, upd_mispredict, flush,
    output pred_hit, pred_taken, pred_target, stat_branches, stat_mispredicts
  );
endinterface

// File: rtl/br_predictor.sv
// Direct-mapped BTB with 2-bit saturating direction counters, zero-latency
// lookup for fetch, update from resolved branches, and saturating
// branch / mispredict statistics.
module br_predictor #(
  parameter int ENTRIES = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  br_predictor_if.slave   bp
);
  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = 32 - IDX_W - 2;

  localparam logic [1:0] CTR_STRONG_NT = 2'b00;
  localparam logic [1:0] CTR_WEAK_NT   = 2'b01;
  localparam logic [1:0] CTR_WEAK_T    = 2'b10;
  localparam logic [1:0] CTR_STRONG_T  = 2'b11;

  logic [ENTRIES-1:0] valid_q, valid_d;
  logic [TAG_W-1:0]   tag_q    [ENTRIES];
  logic [TAG_W-1:0]   tag_d    [ENTRIES];
  logic [31:0]        target_q [ENTRIES];
  logic [31:0]        target_d [ENTRIES];
  logic [1:0]         ctr_q    [ENTRIES];
  logic [1:0]         ctr_d    [ENTRIES];
  logic [31:0]        stat_branches_q, stat_branches_d;
  logic [31:0]        stat_mispredicts_q, stat_mispredicts_d;

  logic [IDX_W-1:0]   lk_idx, upd_idx;
  logic [TAG_W-1:0]   lk_tag, upd_tag;
  logic               lk_hit, lk_taken, upd_hit;

  assign lk_idx  = bp.lk_pc[IDX_W+1:2];
  assign lk_tag  = bp.lk_pc[31:IDX_W+2];
  assign upd_idx = bp.upd_pc[IDX_W+1:2];
  assign upd_tag = bp.upd_pc[31:IDX_W+2];

  // Byte-offset bits of the update PC play no part in indexing or tagging.
  logic unused_upd_pc_lsb;
  assign unused_upd_pc_lsb = ^bp.upd_pc[1:0];

  // Combinational lookup off the current (pre-update) table contents.
  always_comb begin
    lk_hit          = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
    lk_taken        = lk_hit && ctr_q[lk_idx][1];
    bp.pred_hit     = lk_hit;
    bp.pred_taken   = lk_taken;
    bp.pred_target  = lk_taken ? target_q[lk_idx] : bp.lk_pc + 32'd4;
  end

  assign upd_hit = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);

  // Table next state: train on hit, allocate on taken miss, flush clears valids last.
  always_comb begin
    // NOTE: every always_comb output gets a full default first so no path
    // leaves it unassigned, which would otherwise infer a latch.
    valid_d  = valid_q;
    tag_d    = tag_q;
    target_d = target_q;
    ctr_d    = ctr_q;
    if (bp.upd_valid) begin
      if (upd_hit) begin
        if (bp.upd_taken) begin
          if (ctr_q[upd_idx] != CTR_STRONG_T) ctr_d[upd_idx] = ctr_q[upd_idx] + 2'd1;
          target_d[upd_idx] = bp.upd_target;
        end else if (ctr_q[upd_idx] != CTR_STRONG_NT) begin
          ctr_d[upd_idx] = ctr_q[upd_idx] - 2'd1;
        end
      end else if (bp.upd_taken) begin
        valid_d[upd_idx]  = 1'b1;
        tag_d[upd_idx]    = upd_tag;
        target_d[upd_idx] = bp.upd_target;
        ctr_d[upd_idx]    = CTR_WEAK_T;
      end
    end
    // Flush overrides any allocation made in the same cycle.
    if (bp.flush) valid_d = '0;
  end

  // Statistics next state: count resolved branches and mispredicts, saturating.
  always_comb begin
    stat_branches_d    = stat_branches_q;
    stat_mispredicts_d = stat_mispredicts_q;
    if (bp.upd_valid && (stat_branches_q != '1))
      stat_branches_d = stat_branches_q + 32'd1;
    if (bp.upd_valid && bp.upd_mispredict && (stat_mispredicts_q != '1))
      stat_mispredicts_d = stat_mispredicts_q + 32'd1;
  end

  // State registers; asynchronous reset clears the whole table and the stats.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the table is small flop storage whose reset contents are part
      // of the visible behaviour, so every entry is reset, not just valid.
      valid_q <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        ctr_q[i]    <= CTR_WEAK_NT;
      end
      stat_branches_q    <= '0;
      stat_mispredicts_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge values, independent of statement order.
      valid_q            <= valid_d;
      tag_q              <= tag_d;
      target_q           <= target_d;
      ctr_q              <= ctr_d;
      stat_branches_q    <= stat_branches_d;
      stat_mispredicts_q <= stat_mispredicts_d;
    end
  end

  assign bp.stat_branches    = stat_branches_q;
  assign bp.stat_mispredicts = stat_mispredicts_q;
endmodule

// File: tb/tb_br_predictor.sv
// Self-checking bench for br_predictor: directed scenarios with literal
// expectations plus a randomized run compared every cycle to a table model.
module tb_br_predictor;
  localparam int ENTRIES = 16;
  localparam int IDX_W   = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  br_predictor_if bp ();

  br_predictor #(.ENTRIES(ENTRIES)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bp    (bp)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  // ---------------- behavioural model ----------------
  bit          m_valid [ENTRIES];
  logic [31:0] m_tag   [ENTRIES];
  logic [31:0] m_tgt   [ENTRIES];
  int          m_ctr   [ENTRIES];
  logic [31:0] m_br, m_mis;

  function automatic int idx_of(input logic [31:0] pc);
    return int'((pc >> 2) % ENTRIES);
  endfunction

  function automatic logic [31:0] tag_of(input logic [31:0] pc);
    return pc >> (IDX_W + 2);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < ENTRIES; i++) begin
      m_valid[i] = 1'b0; m_tag[i] = '0; m_tgt[i] = '0; m_ctr[i] = 1;
    end
    m_br  = '0;
    m_mis = '0;
  endtask

  task automatic model_clock();
    int i;
    if (bp.upd_valid) begin
      if (m_br  != 32'hFFFF_FFFF) m_br  = m_br + 1;
      if (bp.upd_mispredict && m_mis != 32'hFFFF_FFFF) m_mis = m_mis + 1;
      i = idx_of(bp.upd_pc);
      if (m_valid[i] && m_tag[i] == tag_of(bp.upd_pc)) begin
        if (bp.upd_taken) begin
          m_ctr[i] = (m_ctr[i] + 1 > 3) ? 3 : m_ctr[i] + 1;
          m_tgt[i] = bp.upd_target;
        end else begin
          m_ctr[i] = (m_ctr[i] - 1 < 0) ? 0 : m_ctr[i] - 1;
        end
      end else if (bp.upd_taken) begin
        m_valid[i] = 1'b1;
        m_tag[i]   = tag_of(bp.upd_pc);
        m_tgt[i]   = bp.upd_target;
        m_ctr[i]   = 2;
      end
    end
    if (bp.flush) for (int k = 0; k < ENTRIES; k++) m_valid[k] = 1'b0;
  endtask

  // Model state follows the clock and the asynchronous reset.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) model_reset();
    else        model_clock();
  end

  task automatic compare_outputs();
    int          i;
    bit          h, t;
    logic [31:0] pc;
    pc = bp.lk_pc;
    i  = idx_of(pc);
    h  = m_valid[i] && (m_tag[i] == tag_of(pc));
    t  = h && (m_ctr[i] >= 2);
    check("cmp_hit",    {31'b0, bp.pred_hit},   {31'b0, h});
    check("cmp_taken",  {31'b0, bp.pred_taken}, {31'b0, t});
    check("cmp_target", bp.pred_target, t ? m_tgt[i] : pc + 32'd4);
    check("cmp_branches",    bp.stat_branches,    m_br);
    check("cmp_mispredicts", bp.stat_mispredicts, m_mis);
  endtask

  // Compare DUT against the model mid-cycle, away from the active edge.
  always @(negedge clk) compare_outputs();

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_upd(input logic [31:0] pc, input logic taken, input logic [31:0] tgt,
                           input logic mis, input logic fl);
    bp.upd_valid = 1'b1; bp.upd_pc = pc; bp.upd_taken = taken;
    bp.upd_target = tgt; bp.upd_mispredict = mis; bp.flush = fl;
    step();
    bp.upd_valid = 1'b0; bp.flush = 1'b0; bp.upd_mispredict = 1'b0;
  endtask

  task automatic look(input string name, input logic [31:0] pc, input logic eh,
                      input logic et, input logic [31:0] etgt);
    bp.lk_pc = pc;
    #1;
    check({name, "_hit"},    {31'b0, bp.pred_hit},   {31'b0, eh});
    check({name, "_taken"},  {31'b0, bp.pred_taken}, {31'b0, et});
    check({name, "_target"}, bp.pred_target, etgt);
  endtask

  function automatic logic [31:0] rand_pc();
    logic [31:0] tag;
    case ($urandom_range(0, 3))
      0:       tag = 32'h0;
      1:       tag = 32'h1;
      2:       tag = 32'h2A;
      default: tag = 32'h03FF_FFFF;
    endcase
    return (tag << (IDX_W + 2)) | (32'($urandom_range(0, ENTRIES - 1)) << 2)
           | 32'($urandom_range(0, 3));
  endfunction

  // Watchdog so the run always ends on its own.
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", n_checks);
    $fatal(1);
  end

  // ---------------- test sequence ----------------
  initial begin
    model_reset();
    bp.lk_pc = 32'h100; bp.upd_valid = 0; bp.upd_pc = 0; bp.upd_taken = 0;
    bp.upd_target = 0; bp.upd_mispredict = 0; bp.flush = 0;
    #2;
    look("reset", 32'h100, 0, 0, 32'h104);
    check("reset_branches",    bp.stat_branches,    32'h0);
    check("reset_mispredicts", bp.stat_mispredicts, 32'h0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // First taken allocation.
    drive_upd(32'h100, 1, 32'h200, 1, 0);
    look("alloc", 32'h100, 1, 1, 32'h200);
    check("alloc_branches",    bp.stat_branches,    32'd1);
    check("alloc_mispredicts", bp.stat_mispredicts, 32'd1);

    // 10 -> 01 -> 00 -> 00, then one taken -> 01.
    repeat (3) drive_upd(32'h100, 0, 32'h0, 0, 0);
    look("ctr_sat_low", 32'h100, 1, 0, 32'h104);
    drive_upd(32'h100, 1, 32'h200, 0, 0);
    look("ctr_weak_nt", 32'h100, 1, 0, 32'h104);

    // Aliasing on index 0: 0x140 replaces 0x100 with counter 10.
    drive_upd(32'h140, 1, 32'h300, 0, 0);
    look("alias_new", 32'h140, 1, 1, 32'h300);
    look("alias_old", 32'h100, 0, 0, 32'h104);
    drive_upd(32'h140, 0, 32'h0, 0, 0);
    look("alias_ctr_was_10", 32'h140, 1, 0, 32'h144);

    // Flush and taken update together: no entry survives, stats still count.
    drive_upd(32'h180, 1, 32'h400, 0, 1);
    look("flush_new", 32'h180, 0, 0, 32'h184);
    look("flush_old", 32'h140, 0, 0, 32'h144);
    check("flush_branches", bp.stat_branches, 32'd8);

    // Same-cycle lookup and update of one index returns pre-update state.
    bp.lk_pc = 32'h240;
    bp.upd_valid = 1; bp.upd_pc = 32'h240; bp.upd_taken = 1; bp.upd_target = 32'h500;
    #1;
    check("same_cycle_pre_hit", {31'b0, bp.pred_hit}, 32'd0);
    step();
    bp.upd_valid = 0;
    #1;
    check("same_cycle_post_hit",    {31'b0, bp.pred_hit}, 32'd1);
    check("same_cycle_post_target", bp.pred_target, 32'h500);

    // Randomized traffic with one asynchronous reset in the middle.
    for (int n = 0; n < 1500; n++) begin
      bp.lk_pc          = rand_pc();
      bp.upd_valid      = ($urandom_range(0, 9) < 7);
      bp.upd_pc         = rand_pc();
      bp.upd_taken      = $urandom_range(0, 1);
      bp.upd_target     = $urandom;
      bp.upd_mispredict = $urandom_range(0, 1);
      bp.flush          = ($urandom_range(0, 99) < 3);
      if (n == 700) begin
        #2 rst_n = 1'b0;
        #1;
        check("mid_reset_branches", bp.stat_branches, 32'h0);
        check("mid_reset_hit",      {31'b0, bp.pred_hit}, 32'h0);
        bp.upd_valid = 1'b1; bp.upd_taken = 1'b1;
        step();
        rst_n = 1'b1;
        #1;
        check("reset_discard_branches", bp.stat_branches, 32'h0);
      end else begin
        step();
      end
    end
    bp.upd_valid = 0; bp.flush = 0;

    // Preload both statistics just below saturation and push past it.
    step();
    force dut.stat_branches_q    = 32'hFFFF_FFFE;
    force dut.stat_mispredicts_q = 32'hFFFF_FFFE;
    m_br  = 32'hFFFF_FFFE;
    m_mis = 32'hFFFF_FFFE;
    #1;
    release dut.stat_branches_q;
    release dut.stat_mispredicts_q;
    #1;
    check("sat_preload", bp.stat_branches, 32'hFFFF_FFFE);
    drive_upd(32'h100, 0, 32'h0, 1, 0);
    check("sat_branches_top",    bp.stat_branches,    32'hFFFF_FFFF);
    check("sat_mispredicts_top", bp.stat_mispredicts, 32'hFFFF_FFFF);
    drive_upd(32'h100, 0, 32'h0, 1, 0);
    check("sat_branches_hold",    bp.stat_branches,    32'hFFFF_FFFF);
    check("sat_mispredicts_hold", bp.stat_mispredicts, 32'hFFFF_FFFF);

    // Fall-through target wraps at the top of the address space.
    bp.flush = 1;
    step();
    bp.flush = 0;
    look("wrap", 32'hFFFF_FFFC, 0, 0, 32'h0000_0000);
    check("flush_keeps_stats", bp.stat_branches, 32'hFFFF_FFFF);

    step();
    step();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
